// File: rtl/spy_pkg.sv
// Shared definitions for the spy serial debug protocol: reply/command tags,
// host FSM states and default link timing.
package spy_pkg;

  localparam int SPY_BAUD_DIV = 217;    // 25 MHz / 115200 baud
  localparam int SPY_TIMEOUT  = 65536;  // clk cycles to wait for a reply start bit

  localparam logic [3:0] SPY_TAG_D0 = 4'h3;
  localparam logic [3:0] SPY_TAG_D1 = 4'h4;
  localparam logic [3:0] SPY_TAG_D2 = 4'h5;
  localparam logic [3:0] SPY_TAG_D3 = 4'h6;

  localparam logic [2:0] SPY_CMD_RD = 3'b100;
  localparam logic [2:0] SPY_CMD_WR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_BYTE,
    ST_RX_WAIT,
    ST_RX_BYTE,
    ST_DONE
  } spy_state_e;

  // Data nibble n travels as {tag_n, nibble}; tags are consecutive from D0.
  function automatic logic [7:0] spy_data_byte(input logic [15:0] data, input logic [1:0] n);
    return {SPY_TAG_D0 + {2'b00, n}, data[{n, 2'b00} +: 4]};
  endfunction

endpackage

// File: rtl/spy_uart.sv
// Byte-level 8N1 UART: a transmitter that can chain frames with no idle gap
// and a receiver with a 2-flop synchronizer and mid-bit sampling.
module spy_uart
  import spy_pkg::*;
#(
  parameter int BAUD_DIV = SPY_BAUD_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_frame_err
);

  localparam int             CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]  BIT_HALF = CW'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- TX
  logic          tx_busy;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;    // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]    tx_shift;  // remaining data bits with the stop bit behind them

  // Ready during the last cycle of a stop bit so the next start bit follows
  // immediately.
  assign tx_ready = !tx_busy || (tx_bit == 4'd9 && tx_cnt == BIT_LAST);

  // Frame transmitter: each bit is held for exactly BAUD_DIV cycles.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (tx_load && tx_ready) begin
      tx_busy  <= 1'b1;
      txd      <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= {1'b1, tx_byte};
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          txd      <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- RX
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          rx_fall;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;    // 0 = start check, 1..8 = data, 9 = stop
  logic [7:0]    rx_shift;

  assign rx_fall = rxd_prev && !rxd_sync;

  // Synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Frame receiver: confirm the start bit at half a bit, then sample mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_active    <= 1'b0;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_strobe    <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      if (!rx_active) begin
        if (rx_fall) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_cnt == BIT_HALF) begin
          rx_cnt <= '0;
          if (rxd_sync) rx_active <= 1'b0;  // glitch, not a start bit
          else          rx_bit    <= 4'd1;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (rx_cnt == BIT_LAST) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd9) begin
          rx_active    <= 1'b0;
          rx_strobe    <= 1'b1;
          rx_frame_err <= !rxd_sync;
          rx_data      <= rx_shift;
        end else begin
          rx_bit   <= rx_bit + 4'd1;
          rx_shift <= {rxd_sync, rx_shift[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spy_host.sv
// Host-side spy initiator: turns one register request into command bytes and,
// for reads, reassembles the 16-bit value from four tagged reply bytes.
module spy_host
  import spy_pkg::*;
#(
  parameter int BAUD_DIV = SPY_BAUD_DIV,
  parameter int TIMEOUT  = SPY_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic        rs232_txd,
  input  logic        rs232_rxd
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  spy_state_e    state;
  logic          wr_r;
  logic [4:0]    addr_r;
  logic [15:0]   data_r;
  logic [2:0]    tx_idx;
  logic [1:0]    rx_idx;
  logic [11:0]   nib_r;
  logic [TW-1:0] tmo_cnt;

  logic          tx_load, tx_ready;
  logic [7:0]    tx_byte;
  logic          rx_active, rx_strobe, rx_frame_err;
  logic [7:0]    rx_data;
  logic          accept, last_byte, tag_ok;
  logic [2:0]    next_idx;

  assign accept    = (state == ST_IDLE) && req_valid && req_ready;
  assign last_byte = wr_r ? (tx_idx == 3'd4) : 1'b1;
  assign next_idx  = tx_idx + 3'd1;
  assign tag_ok    = (rx_data[7:4] == SPY_TAG_D0 + {2'b00, rx_idx});

  // Byte feed to the UART: first byte straight from the request, the rest
  // on the last stop-bit cycle of the previous byte.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    if (accept) begin
      tx_load = 1'b1;
      tx_byte = req_write ? spy_data_byte(req_data, 2'd0) : {SPY_CMD_RD, req_addr};
    end else if (state == ST_TX_BYTE && tx_ready && !last_byte) begin
      tx_load = 1'b1;
      tx_byte = (next_idx == 3'd4) ? {SPY_CMD_WR, addr_r}
                                   : spy_data_byte(data_r, next_idx[1:0]);
    end
  end

  // Request sequencer with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      wr_r      <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      nib_r     <= '0;
      tmo_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            wr_r      <= req_write;
            addr_r    <= req_addr;
            data_r    <= req_data;
            tx_idx    <= '0;
            req_ready <= 1'b0;
            state     <= ST_TX_BYTE;
          end
        end
        ST_TX_BYTE: begin
          if (tx_ready) begin
            if (!last_byte) begin
              tx_idx <= next_idx;
            end else if (wr_r) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              state     <= ST_DONE;
            end else begin
              rx_idx  <= '0;
              tmo_cnt <= '0;
              state   <= ST_RX_WAIT;
            end
          end
        end
        ST_RX_WAIT: begin
          if (rx_active) begin
            state <= ST_RX_BYTE;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            state     <= ST_DONE;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RX_BYTE: begin
          if (rx_strobe) begin
            if (rx_frame_err || !tag_ok) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_DONE;
            end else if (rx_idx == 2'd3) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= {rx_data[3:0], nib_r};
              state     <= ST_DONE;
            end else begin
              case (rx_idx)
                2'd0:    nib_r[3:0]  <= rx_data[3:0];
                2'd1:    nib_r[7:4]  <= rx_data[3:0];
                default: nib_r[11:8] <= rx_data[3:0];
              endcase
              rx_idx  <= rx_idx + 2'd1;
              tmo_cnt <= '0;
              state   <= ST_RX_WAIT;
            end
          end else if (!rx_active) begin
            // Start bit rejected as a glitch; keep waiting on the same timer.
            state <= ST_RX_WAIT;
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spy_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk          (clk),
    .reset        (reset),
    .tx_load      (tx_load),
    .tx_byte      (tx_byte),
    .tx_ready     (tx_ready),
    .txd          (rs232_txd),
    .rxd          (rs232_rxd),
    .rx_active    (rx_active),
    .rx_data      (rx_data),
    .rx_strobe    (rx_strobe),
    .rx_frame_err (rx_frame_err)
  );

endmodule

// File: tb/tb_spy_host.sv
// Self-checking bench for spy_host: directed protocol cases plus randomized
// transactions against a byte-level reference of the spy protocol.
module tb_spy_host;

  localparam int B = 16;    // clk cycles per bit
  localparam int T = 1000;  // reply timeout in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [4:0]  req_addr;
  logic [15:0] req_data;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic        rs232_txd, rs232_rxd;

  spy_host #(.BAUD_DIV(B), .TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .rs232_txd (rs232_txd),
    .rs232_rxd (rs232_rxd)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Observed transaction state
  int          acc_cyc, rsp_cyc;
  bit          got_rsp;
  logic        got_err;
  logic [15:0] got_data;
  logic [15:0] model_data = 16'h0;  // rsp_data the protocol says is held

  // Decoded txd frames
  logic [7:0] mon_bytes[$];
  int         mon_starts[$];
  logic       mon_stops[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // txd frame decoder: sample each bit in its middle, log start cycle.
  initial begin : tx_monitor
    logic       prev;
    logic [7:0] b;
    int         st;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !rs232_txd) begin
        st = cyc;
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = rs232_txd;
        end
        repeat (B) @(negedge clk);
        mon_bytes.push_back(b);
        mon_starts.push_back(st);
        mon_stops.push_back(rs232_txd);
      end
      prev = rs232_txd;
    end
  end

  // Reference: expected response of a read from its four reply bytes.
  function automatic logic [16:0] ref_read(input logic [31:0] rep);
    logic [15:0] d;
    logic [7:0]  by;
    bit          bad;
    d   = '0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      by = rep[8*k +: 8];
      if (by[7:4] != 4'(3 + k)) bad = 1'b1;
      d[4*k +: 4] = by[3:0];
    end
    return bad ? 17'h10000 : {1'b0, d};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rs232_rxd = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = b[i];
      repeat (B) @(negedge clk);
    end
    rs232_rxd = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic issue(input bit wr, input logic [4:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 5'($urandom);
    req_data  = 16'($urandom);
    check("req_ready_drop", req_ready, 0);
  endtask

  task automatic wait_rsp(input int budget);
    got_rsp = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        got_rsp  = 1'b1;
        rsp_cyc  = cyc;
        got_err  = rsp_err;
        got_data = rsp_data;
        break;
      end
    end
    check("rsp_arrived", got_rsp, 1);
    if (got_rsp) begin
      @(posedge clk);
      #1;
      check("rsp_one_cycle", rsp_valid, 0);
      check("req_ready_back", req_ready, 1);
    end
  endtask

  task automatic run_txn(input bit wr, input logic [4:0] a, input logic [15:0] d,
                         input logic [31:0] rep, input bit reply, input bit glitch);
    logic [7:0]  exp_tx[$];
    logic [16:0] exp_rsp;
    int          n;
    mon_bytes.delete();
    mon_starts.delete();
    mon_stops.delete();
    if (wr) begin
      for (int k = 0; k < 4; k++) exp_tx.push_back({4'(3 + k), d[4*k +: 4]});
      exp_tx.push_back({3'b101, a});
      exp_rsp = {1'b0, model_data};
    end else begin
      exp_tx.push_back({3'b100, a});
      exp_rsp = reply ? ref_read(rep) : 17'h10000;
    end
    model_data = exp_rsp[15:0];

    issue(wr, a, d);
    if (wr || !reply) begin
      wait_rsp(60 * B + T + 100);
    end else begin
      n = 0;
      while (mon_bytes.size() == 0 && n < 20 * B) begin
        @(negedge clk);
        n++;
      end
      check("cmd_byte_seen", 32'(mon_bytes.size()), 1);
      repeat (B) @(negedge clk);
      if (glitch) begin
        rs232_rxd = 1'b0;
        repeat (2) @(negedge clk);
        rs232_rxd = 1'b1;
        repeat (3 * B) @(negedge clk);
      end
      fork
        for (int k = 0; k < 4; k++) send_byte(rep[8*k +: 8]);
        wait_rsp(60 * B);
      join
    end

    if (got_rsp) begin
      check("rsp_err", got_err, exp_rsp[16]);
      check("rsp_data", got_data, exp_rsp[15:0]);
      if (wr)          check("write_rsp_cycle", rsp_cyc - acc_cyc, 50 * B);
      else if (!reply) check("timeout_rsp_cycle", rsp_cyc - acc_cyc, 10 * B + T);
    end
    check("tx_byte_count", 32'(mon_bytes.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < mon_bytes.size(); i++) begin
      check("tx_byte", mon_bytes[i], exp_tx[i]);
      check("tx_frame_start", mon_starts[i] - acc_cyc, 10 * B * i);
      check("tx_stop_bit", mon_stops[i], 1);
    end
  endtask

  initial begin : main
    logic [31:0] rep;
    logic [3:0]  tag;
    bit          wr, bad, saw;
    int          bk;

    reset     = 1'b1;
    rs232_rxd = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_data", rsp_data, 16'h0);
    check("reset_txd", rs232_txd, 1);

    // Write 0x1234 to 0x02: 0x34 0x43 0x52 0x61 0xA2 back to back
    run_txn(1'b1, 5'h02, 16'h1234, 32'h0, 1'b0, 1'b0);
    // Read 0x12 with a clean reply
    run_txn(1'b0, 5'h12, 16'h0, {8'h68, 8'h50, 8'h41, 8'h32}, 1'b1, 1'b0);
    // Read 0x03 with no reply
    run_txn(1'b0, 5'h03, 16'h0, 32'h0, 1'b0, 1'b0);
    // Read with a bad second reply byte, then a normal read
    run_txn(1'b0, 5'h07, 16'h0, {8'h6b, 8'h5a, 8'h71, 8'h35}, 1'b1, 1'b0);
    run_txn(1'b0, 5'h1f, 16'h0, {8'h6c, 8'h5d, 8'h4e, 8'h3f}, 1'b1, 1'b0);
    // Glitch on rxd before a valid reply
    run_txn(1'b0, 5'h0a, 16'h0, {8'h6a, 8'h55, 8'h4c, 8'h39}, 1'b1, 1'b1);

    // Reset during the start bit of the 3rd write byte
    mon_bytes.delete();
    issue(1'b1, 5'h15, 16'hbeef);
    repeat (20 * B + 2) @(posedge clk);
    #1;
    check("third_byte_start_bit", rs232_txd, 0);
    reset = 1'b1;
    #1;
    check("reset_mid_txd", rs232_txd, 1);
    check("reset_mid_req_ready", req_ready, 1);
    check("reset_mid_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (12 * B) begin
      @(posedge clk);
      #1;
      if (rsp_valid) saw = 1'b1;
    end
    check("no_rsp_after_reset", saw, 0);
    model_data = 16'h0;
    run_txn(1'b1, 5'h15, 16'hbeef, 32'h0, 1'b0, 1'b0);

    // Randomized transactions, some with one corrupted reply tag
    for (int t = 0; t < 10; t++) begin
      wr  = 1'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      bk  = $urandom_range(0, 3);
      rep = '0;
      for (int k = 0; k < 4; k++) begin
        tag = 4'(3 + k);
        if (bad && k == bk) tag = tag ^ 4'($urandom_range(1, 15));
        rep[8*k +: 8] = {tag, 4'($urandom_range(0, 15))};
      end
      run_txn(wr, 5'($urandom), 16'($urandom), rep, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
